// File: rtl/hdlc_pkg.sv
// Shared constants for the HDLC transmit framer: FSM state codes, flag
// pattern, bit-stuffing threshold and per-frame counter width.
package hdlc_pkg;

   localparam int         CNT_W      = 13;
   localparam int         ONES_LIMIT = 5;
   localparam logic [7:0] FLAG_BYTE  = 8'h7E;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_OPEN  = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STUFF = 3'd3;
   localparam logic [2:0] ST_CLOSE = 3'd4;

endpackage

// File: rtl/hdlc_out_reg.sv
// One-deep registered output slot. A new bit is taken whenever the slot is
// empty or its current bit is being consumed; otherwise everything holds.
module hdlc_out_reg (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic load,
   input  logic d_bit,
   input  logic d_stuff,
   input  logic d_flag,
   input  logic out_ready,
   output logic out_bit,
   output logic out_valid,
   output logic out_stuff,
   output logic out_flag,
   output logic slot_free
);

   assign slot_free = ~out_valid | out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_stuff <= 1'b0;
         out_flag  <= 1'b0;
      end else if (clr) begin
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_stuff <= 1'b0;
         out_flag  <= 1'b0;
      end else if (slot_free) begin
         // an idle free slot drops valid and parks the sideband at 0
         out_valid <= load;
         out_bit   <= load & d_bit;
         out_stuff <= load & d_stuff;
         out_flag  <= load & d_flag;
      end
   end

endmodule

// File: rtl/hdlc_bit_stuffer.sv
// HDLC transmit framer: wraps each payload frame in flag bytes and inserts
// a 0 after every run of ONES_LIMIT payload 1s, with per-frame statistics.
module hdlc_bit_stuffer
   import hdlc_pkg::*;
#(
   parameter int         ONES_LIMIT = hdlc_pkg::ONES_LIMIT,
   parameter logic [7:0] FLAG_BYTE  = hdlc_pkg::FLAG_BYTE,
   parameter int         CNT_W      = hdlc_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inr,
   input  logic             in_bit,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_stuff,
   output logic             out_flag,
   output logic             frame_done,
   output logic [CNT_W-1:0] stuff_cnt,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam int             OW        = $clog2(ONES_LIMIT + 1);
   localparam logic [OW-1:0]  ONES_TRIG = OW'(ONES_LIMIT - 1);
   localparam logic [OW-1:0]  ONES_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [2:0]    state;
   logic [2:0]    flag_idx;
   logic [OW-1:0] ones_cnt;
   logic          pend_last;
   logic          slot_free;
   logic          emit, e_bit, e_stuff, e_flag;

   assign in_ready = (state == ST_DATA) & slot_free;

   always_comb begin
      emit    = 1'b0;
      e_bit   = 1'b0;
      e_stuff = 1'b0;
      e_flag  = 1'b0;
      case (state)
         ST_OPEN, ST_CLOSE: begin
            emit   = 1'b1;
            e_bit  = FLAG_BYTE[flag_idx];
            e_flag = 1'b1;
         end
         ST_DATA: begin
            emit  = in_valid;
            e_bit = in_bit;
         end
         ST_STUFF: begin
            emit    = 1'b1;
            e_stuff = 1'b1;
         end
         default: ;
      endcase
   end

   hdlc_out_reg u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (inr),
      .load      (emit),
      .d_bit     (e_bit),
      .d_stuff   (e_stuff),
      .d_flag    (e_flag),
      .out_ready (out_ready),
      .out_bit   (out_bit),
      .out_valid (out_valid),
      .out_stuff (out_stuff),
      .out_flag  (out_flag),
      .slot_free (slot_free)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         flag_idx   <= '0;
         ones_cnt   <= '0;
         pend_last  <= 1'b0;
         frame_done <= 1'b0;
         bit_cnt    <= '0;
         stuff_cnt  <= '0;
      end else if (inr) begin
         state      <= ST_IDLE;
         flag_idx   <= '0;
         ones_cnt   <= '0;
         pend_last  <= 1'b0;
         frame_done <= 1'b0;
         bit_cnt    <= '0;
         stuff_cnt  <= '0;
      end else begin
         frame_done <= 1'b0;
         // everything advances only with the output slot, so a stall freezes the frame
         if (slot_free) begin
            case (state)
               ST_IDLE: if (in_valid) begin
                  state     <= ST_OPEN;
                  bit_cnt   <= '0;
                  stuff_cnt <= '0;
                  ones_cnt  <= '0;
               end
               ST_OPEN: begin
                  flag_idx <= flag_idx + 3'd1;
                  if (flag_idx == 3'd7) state <= ST_DATA;
               end
               ST_DATA: if (in_valid) begin
                  if (!(&bit_cnt)) bit_cnt <= bit_cnt + CNT_ONE;
                  if (in_bit && ones_cnt == ONES_TRIG) begin
                     ones_cnt  <= '0;
                     pend_last <= in_last;
                     state     <= ST_STUFF;
                  end else begin
                     ones_cnt <= in_bit ? ones_cnt + ONES_ONE : '0;
                     if (in_last) state <= ST_CLOSE;
                  end
               end
               ST_STUFF: begin
                  if (!(&stuff_cnt)) stuff_cnt <= stuff_cnt + CNT_ONE;
                  state     <= pend_last ? ST_CLOSE : ST_DATA;
                  pend_last <= 1'b0;
               end
               ST_CLOSE: begin
                  flag_idx <= flag_idx + 3'd1;
                  if (flag_idx == 3'd7) begin
                     frame_done <= 1'b1;
                     state      <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hdlc_bit_stuffer.sv
// Randomized scoreboard bench for hdlc_bit_stuffer: a frame-level model
// queues the expected serial stream and a monitor checks every transfer.
module tb_hdlc_bit_stuffer;

   localparam int CW = 13;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          inr = 1'b0;
   logic          in_bit = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b1;
   logic          in_ready, out_bit, out_valid, out_stuff, out_flag, frame_done;
   logic [CW-1:0] stuff_cnt, bit_cnt;

   hdlc_bit_stuffer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inr        (inr),
      .in_bit     (in_bit),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .out_bit    (out_bit),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_stuff  (out_stuff),
      .out_flag   (out_flag),
      .frame_done (frame_done),
      .stuff_cnt  (stuff_cnt),
      .bit_cnt    (bit_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic b;
      logic s;
      logic f;
      logic last;
   } exp_t;

   exp_t expq[$];
   bit   payload[$];
   bit   stuff_after[$];
   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   stall_mode = 0;
   int   exp_stuff = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected line stream from the HDLC rules: flag, payload with a 0 after
   // every 5th consecutive 1, flag.
   function automatic int model_frame();
      logic [7:0] fl = 8'h7E;
      int run = 0;
      int ns  = 0;
      stuff_after.delete();
      for (int i = 0; i < 8; i++) expq.push_back('{fl[i], 1'b0, 1'b1, 1'b0});
      foreach (payload[i]) begin
         expq.push_back('{payload[i], 1'b0, 1'b0, 1'b0});
         run = payload[i] ? run + 1 : 0;
         if (run == 5) begin
            expq.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
            ns++;
            run = 0;
            stuff_after.push_back(1'b1);
         end else begin
            stuff_after.push_back(1'b0);
         end
      end
      for (int i = 0; i < 8; i++) expq.push_back('{fl[i], 1'b0, 1'b1, i == 7});
      return ns;
   endfunction

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = (stall_mode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   logic prev_stall = 1'b0;
   logic prev_bit = 1'b0;
   always @(negedge clk) begin
      if (!rst_n || inr) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && out_valid) chk("stall_hold", out_bit, prev_bit);
         if (frame_done) begin
            done_cnt++;
            if (expq.size() == 0) chk("frame_done_unexpected", 1, 0);
            else chk("frame_done_pos", expq[0].last, 1);
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               chk("extra_output", 1, 0);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("out_bit", out_bit, e.b);
               chk("out_stuff", out_stuff, e.s);
               chk("out_flag", out_flag, e.f);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_bit   = out_bit;
      end
   end

   // Drives the payload; abort_at>0 pulses inr after that many accepted bits.
   task automatic drive_payload(input int abort_at);
      int t;
      foreach (payload[i]) begin
         in_valid = 1'b1;
         in_bit   = payload[i];
         in_last  = (i == payload.size() - 1);
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!in_ready && t < 2000);
         if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            break;
         end
         @(posedge clk);
         #1;
         if (stuff_after[i]) begin
            @(negedge clk);
            chk("in_ready_stuff", in_ready, 0);
         end
         if (i + 1 == abort_at) begin
            in_valid = 1'b0;
            inr = 1'b1;
            @(posedge clk);
            #1;
            inr = 1'b0;
            expq.delete();
            @(negedge clk);
            chk("inr_out_valid", out_valid, 0);
            chk("inr_bit_cnt", bit_cnt, 0);
            chk("inr_stuff_cnt", stuff_cnt, 0);
            chk("inr_in_ready", in_ready, 0);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_frame();
      int t;
      int d0;
      d0 = done_cnt;
      exp_stuff = model_frame();
      drive_payload(0);
      t = 0;
      while (expq.size() != 0 && t < 5000) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("drain_timeout", expq.size(), 0);
      expq.delete();
      repeat (2) @(negedge clk);
      chk("bit_cnt", bit_cnt, payload.size());
      chk("stuff_cnt", stuff_cnt, exp_stuff);
      chk("frame_done_count", done_cnt - d0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_bit"}, out_bit, 0);
      chk({tag, "_out_stuff"}, out_stuff, 0);
      chk({tag, "_out_flag"}, out_flag, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_bit_cnt"}, bit_cnt, 0);
      chk({tag, "_stuff_cnt"}, stuff_cnt, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
   endtask

   task automatic load_ff();
      payload.delete();
      for (int i = 0; i < 8; i++) payload.push_back(1'b1);
   endtask

   initial begin
      int t;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // 0xFF frame: one stuffed zero after the fifth 1
      load_ff();
      run_frame();
      chk("ff_stuff_cnt", stuff_cnt, 1);

      // fifth 1 carries in_last: stuffed 0 precedes closing flag
      payload.delete();
      for (int i = 0; i < 5; i++) payload.push_back(1'b1);
      run_frame();
      chk("last5_stuff_cnt", stuff_cnt, 1);

      payload.delete();
      for (int i = 0; i < 15; i++) payload.push_back(1'b1);
      run_frame();
      chk("ones15_stuff_cnt", stuff_cnt, 3);

      payload = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      run_frame();
      chk("broken_run_stuff_cnt", stuff_cnt, 0);

      // single-bit frame
      payload = '{1'b1};
      run_frame();

      // same 32-bit payload without and with back-pressure
      payload.delete();
      for (int i = 0; i < 32; i++) payload.push_back($urandom_range(0, 3) != 0);
      run_frame();
      stall_mode = 1;
      run_frame();
      stall_mode = 0;

      // abort after 10 bits, then a fresh frame
      payload.delete();
      for (int i = 0; i < 20; i++) payload.push_back(i[0]);
      void'(model_frame());
      drive_payload(10);
      load_ff();
      run_frame();

      // async reset while the closing flag is going out
      load_ff();
      void'(model_frame());
      drive_payload(0);
      t = 0;
      while (expq.size() > 4 && t < 5000) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("close_reach_timeout", expq.size(), 4);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      expq.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      load_ff();
      run_frame();
      chk("post_rst_stuff_cnt", stuff_cnt, 1);

      // random frames, random back-pressure
      for (int f = 0; f < 8; f++) begin
         int len;
         len = $urandom_range(1, 40);
         payload.delete();
         for (int i = 0; i < len; i++) payload.push_back($urandom_range(0, 3) != 0);
         stall_mode = f[0];
         run_frame();
      end
      stall_mode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
